dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter WORD_LEN, default 32, data/address width in bits.
REQ-002 Parameter STARVE_LIMIT, default 8, consecutive cycles a pending DMA request may be refused before forced grant.
REQ-003 Parameter LEN_W, default 4, width of the DMA burst-length field.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cpu_req  in  1  pipeline MEM-stage access request (load or store).
REQ-007 cpu_we  in  1  1 = store, 0 = load.
REQ-008 cpu_addr, cpu_wdata  in  WORD_LEN  byte address, store data.
REQ-009 cpu_rdata  out  WORD_LEN  load data, valid while cpu_ready=1.
REQ-010 cpu_ready  out  1  access completes this cycle; 0 = pipeline stall.
REQ-011 dma_req  in  1  burst request, held until dma_done.
REQ-012 dma_we, dma_addr, dma_len  in  1, WORD_LEN, LEN_W  direction, start byte address, word count minus 1; sampled at burst grant.
REQ-013 dma_wdata  in  WORD_LEN  write data for the current beat.
REQ-014 dma_beat  out  1  one word transferred this cycle; dma_wdata consumed or dma_rdata valid.
REQ-015 dma_rdata  out  WORD_LEN  read data for the current beat.
REQ-016 dma_done  out  1  single-cycle pulse on the last beat.
REQ-017 mem_writeEn, mem_readEn  out  1  data-memory strobes.
REQ-018 mem_address, mem_dataIn  out  WORD_LEN  to memory; mem_dataOut  in  WORD_LEN  combinational read data from memory.

Function
REQ-019 FSM states IDLE, CPU, DMA; at most one requester drives memory per cycle.
REQ-020 IDLE/CPU: a cpu_req is serviced in the same cycle (cpu_ready=1, strobes and address driven from cpu_* combinationally) unless the starvation rule applies.
REQ-021 Starve counter increments each cycle dma_req=1 while not in DMA and saturates at STARVE_LIMIT; it clears on DMA entry.
REQ-022 Transition to DMA at a clock edge when dma_req=1 and either cpu_req=0 or the counter equals STARVE_LIMIT; a CPU access in that same cycle completes normally.
REQ-023 At DMA entry: latch dma_addr with its two LSBs forced to 0, latch dma_we, and load the beat counter with dma_len.
REQ-024 In DMA, one beat per cycle: dma_beat=1, mem_address = latched address, mem_writeEn = latched we, mem_readEn = not latched we.
REQ-025 After each beat, the address advances by 4 and wraps modulo 2^WORD_LEN; the beat counter decrements.
REQ-026 On the beat where the counter is 0: dma_done=1, then the FSM goes to IDLE on the next edge; total beats = dma_len+1.
REQ-027 In DMA, cpu_ready=0 and cpu_req is ignored; the stalled CPU access issues only after return to IDLE.
REQ-028 dma_req falling mid-burst does not abort; the burst runs to completion.
REQ-029 cpu_rdata = dma_rdata = mem_dataOut at all times; cpu_ready and dma_beat qualify them.
REQ-030 cpu_addr passes to memory unmodified; memory performs word alignment.
REQ-031 Strobes are 0 whenever no access is granted; mem_writeEn and mem_readEn are never 1 together.

Reset
REQ-032 While rst=1: state IDLE, starve counter 0, beat counter 0, latched address 0; cpu_ready, dma_beat, dma_done, mem_writeEn, mem_readEn all 0.
REQ-033 rst asserted mid-burst aborts the burst at that edge with no dma_done; the first cycle after reset behaves as IDLE.

Verification
REQ-034 CPU store addr 0x10 data 0x90, no DMA -> same cycle mem_writeEn=1, mem_address=0x10, cpu_ready=1; a load from 0x10 next cycle returns 0x90.
REQ-035 Idle CPU, DMA read at addr 0x20, len 3 -> 4 beats at 0x20, 0x24, 0x28, 0x2C with mem_readEn=1, dma_done on the 4th beat, then IDLE.
REQ-036 cpu_req held high continuously plus dma_req with STARVE_LIMIT=8 -> DMA granted after 8 refused cycles; cpu_ready=0 for exactly len+1 cycles.
REQ-037 DMA write at addr 0x07 -> first beat address 0x04.
REQ-038 DMA write at addr 0xFFFFFFFC, len 1 -> beats at 0xFFFFFFFC then 0x00000000.
REQ-039 rst pulsed on the 2nd beat of a 4-beat burst -> no further strobes, no dma_done; the next cycle a cpu_req is served with cpu_ready=1.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the pipeline MEM stage and a burst DMA engine.
// The CPU is served combinationally; DMA bursts take the memory with starvation protection.
module dmem_arbiter #(
  parameter int WORD_LEN     = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int LEN_W        = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [WORD_LEN-1:0] cpu_addr,
  input  logic [WORD_LEN-1:0] cpu_wdata,
  output logic [WORD_LEN-1:0] cpu_rdata,
  output logic                cpu_ready,
  input  logic                dma_req,
  input  logic                dma_we,
  input  logic [WORD_LEN-1:0] dma_addr,
  input  logic [LEN_W-1:0]    dma_len,
  input  logic [WORD_LEN-1:0] dma_wdata,
  output logic                dma_beat,
  output logic [WORD_LEN-1:0] dma_rdata,
  output logic                dma_done,
  output logic                mem_writeEn,
  output logic                mem_readEn,
  output logic [WORD_LEN-1:0] mem_address,
  output logic [WORD_LEN-1:0] mem_dataIn,
  input  logic [WORD_LEN-1:0] mem_dataOut
);

  localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    DMA  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [WORD_LEN-1:0] addr_q, addr_d;
  logic                we_q, we_d;

  assign cpu_rdata = mem_dataOut;
  assign dma_rdata = mem_dataOut;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      beat_cnt_q <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      beat_cnt_q <= beat_cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    beat_cnt_d  = beat_cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    cpu_ready   = 1'b0;
    dma_beat    = 1'b0;
    dma_done    = 1'b0;
    mem_writeEn = 1'b0;
    mem_readEn  = 1'b0;
    mem_address = '0;
    mem_dataIn  = '0;

    unique case (state_q)
      DMA: begin
        dma_beat    = 1'b1;
        mem_address = addr_q;
        mem_dataIn  = dma_wdata;
        mem_writeEn = we_q;
        mem_readEn  = ~we_q;
        addr_d      = addr_q + WORD_LEN'(4);
        if (beat_cnt_q == '0) begin
          dma_done = 1'b1;
          state_d  = IDLE;
        end else begin
          beat_cnt_d = beat_cnt_q - LEN_W'(1);
        end
      end
      default: begin
        if (cpu_req) begin
          cpu_ready   = 1'b1;
          mem_address = cpu_addr;
          mem_dataIn  = cpu_wdata;
          mem_writeEn = cpu_we;
          mem_readEn  = ~cpu_we;
        end
        // The CPU access of this cycle still completes; the burst starts next edge.
        if (dma_req && (!cpu_req || starve_q == STARVE_MAX)) begin
          state_d    = DMA;
          starve_d   = '0;
          addr_d     = dma_addr & ~WORD_LEN'(3);
          we_d       = dma_we;
          beat_cnt_d = dma_len;
        end else begin
          state_d = cpu_req ? CPU : IDLE;
          if (dma_req && starve_q != STARVE_MAX) begin
            starve_d = starve_q + STARVE_W'(1);
          end
        end
      end
    endcase

    if (rst) begin
      cpu_ready   = 1'b0;
      dma_beat    = 1'b0;
      dma_done    = 1'b0;
      mem_writeEn = 1'b0;
      mem_readEn  = 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random traffic,
// compared cycle by cycle against a transaction-level model with a reference memory.
module tb_dmem_arbiter;
  localparam int WORD_LEN     = 32;
  localparam int STARVE_LIMIT = 8;
  localparam int LEN_W        = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [3:0]  dma_len;
  logic        dma_beat, dma_done;
  logic        mem_writeEn, mem_readEn;
  logic [31:0] mem_address, mem_dataIn, mem_dataOut;

  logic        nx_rst, nx_cpu_req, nx_cpu_we, nx_dma_req, nx_dma_we;
  logic [31:0] nx_cpu_addr, nx_cpu_wdata, nx_dma_addr, nx_dma_wdata;
  logic [3:0]  nx_dma_len;

  logic [31:0] mem_arr [256];
  logic [31:0] ref_mem [256];
  logic        mem_load;

  int          checks = 0;
  int          failures = 0;
  int          refused = 0;
  logic [31:0] beat_addrs [$];
  logic        burst_we = 1'b0;
  logic        model_done = 1'b0;

  dmem_arbiter #(
    .WORD_LEN(WORD_LEN),
    .STARVE_LIMIT(STARVE_LIMIT),
    .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_beat(dma_beat), .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_writeEn(mem_writeEn), .mem_readEn(mem_readEn), .mem_address(mem_address),
    .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] initWord(input int i);
    return (32'h9E37_79B9 * 32'(i + 1)) ^ 32'h0F0F_1234;
  endfunction

  // Word-aligned memory with combinational read, as the arbiter expects.
  assign mem_dataOut = mem_arr[mem_address[9:2]];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= initWord(i);
    end else if (mem_writeEn) begin
      mem_arr[mem_address[9:2]] <= mem_dataIn;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    rst       = nx_rst;
    cpu_req   = nx_cpu_req;
    cpu_we    = nx_cpu_we;
    cpu_addr  = nx_cpu_addr;
    cpu_wdata = nx_cpu_wdata;
    dma_req   = nx_dma_req;
    dma_we    = nx_dma_we;
    dma_addr  = nx_dma_addr;
    dma_len   = nx_dma_len;
    dma_wdata = nx_dma_wdata;
  endtask

  // Model: a granted burst becomes a queue of beat addresses; otherwise the CPU owns memory.
  task automatic checkOutput();
    logic [31:0] a;
    logic        last;
    #3;
    model_done = 1'b0;
    if (rst) begin
      check("rst_cpu_ready", cpu_ready, 0);
      check("rst_dma_beat", dma_beat, 0);
      check("rst_dma_done", dma_done, 0);
      check("rst_wen", mem_writeEn, 0);
      check("rst_ren", mem_readEn, 0);
      beat_addrs.delete();
      refused = 0;
    end else if (beat_addrs.size() != 0) begin
      a    = beat_addrs.pop_front();
      last = (beat_addrs.size() == 0);
      check("dma_beat", dma_beat, 1);
      check("dma_address", mem_address, a);
      check("dma_wen", mem_writeEn, burst_we);
      check("dma_ren", mem_readEn, !burst_we);
      check("dma_done", dma_done, last);
      check("dma_cpu_stall", cpu_ready, 0);
      if (burst_we) begin
        check("dma_wdata", mem_dataIn, dma_wdata);
        ref_mem[a[9:2]] = dma_wdata;
      end else begin
        check("dma_rdata", dma_rdata, ref_mem[a[9:2]]);
      end
      model_done = last;
    end else begin
      check("cpu_ready", cpu_ready, cpu_req);
      check("idle_beat", dma_beat, 0);
      check("idle_done", dma_done, 0);
      check("cpu_wen", mem_writeEn, cpu_req & cpu_we);
      check("cpu_ren", mem_readEn, cpu_req & ~cpu_we);
      if (cpu_req) begin
        check("cpu_address", mem_address, cpu_addr);
        if (cpu_we) begin
          check("cpu_wdata", mem_dataIn, cpu_wdata);
          ref_mem[cpu_addr[9:2]] = cpu_wdata;
        end else begin
          check("cpu_rdata", cpu_rdata, ref_mem[cpu_addr[9:2]]);
        end
      end
      if (dma_req && (!cpu_req || refused == STARVE_LIMIT)) begin
        a = dma_addr & 32'hFFFF_FFFC;
        for (int i = 0; i <= int'(dma_len); i++) begin
          beat_addrs.push_back(a);
          a = a + 32'd4;
        end
        burst_we = dma_we;
        refused  = 0;
      end else if (dma_req && refused < STARVE_LIMIT) begin
        refused++;
      end
    end
  endtask

  task automatic tick();
    applyStimulus();
    checkOutput();
  endtask

  task automatic runBurst(input logic we, input logic [31:0] addr, input logic [3:0] len,
                          input bit cpu_busy, input bit drop_early, output int stalls);
    int dones = 0;
    stalls      = 0;
    nx_dma_req  = 1'b1;
    nx_dma_we   = we;
    nx_dma_addr = addr;
    nx_dma_len  = len;
    for (int c = 0; c < 80; c++) begin
      nx_cpu_req   = cpu_busy;
      nx_cpu_we    = 1'($urandom_range(0, 1));
      nx_cpu_addr  = 32'($urandom_range(0, 1023));
      nx_cpu_wdata = $urandom;
      nx_dma_wdata = $urandom;
      tick();
      if (cpu_busy && !cpu_ready) stalls++;
      if (dma_done === 1'b1) dones++;
      if (drop_early && beat_addrs.size() != 0) nx_dma_req = 1'b0;
      if (model_done) break;
    end
    nx_dma_req = 1'b0;
    nx_cpu_req = 1'b0;
    check("done_pulses", 32'(dones), 1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int stalls;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_len = '0; dma_wdata = '0;
    nx_rst = 1'b1; nx_cpu_req = 1'b0; nx_cpu_we = 1'b0; nx_cpu_addr = '0; nx_cpu_wdata = '0;
    nx_dma_req = 1'b0; nx_dma_we = 1'b0; nx_dma_addr = '0; nx_dma_len = '0; nx_dma_wdata = '0;
    mem_load = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = initWord(i);

    tick();
    mem_load = 1'b0;
    tick();
    nx_rst = 1'b0;

    // Store then load at 0x10 with no DMA activity.
    nx_cpu_req = 1'b1; nx_cpu_we = 1'b1; nx_cpu_addr = 32'h10; nx_cpu_wdata = 32'h90;
    tick();
    check("store_wen", mem_writeEn, 1);
    nx_cpu_we = 1'b0;
    tick();
    check("load_after_store", cpu_rdata, 32'h90);
    nx_cpu_req = 1'b0;
    tick();

    $display("[TB] DMA read 0x20 len 3");
    runBurst(1'b0, 32'h20, 4'd3, 1'b0, 1'b0, stalls);
    tick();

    $display("[TB] starvation with CPU held busy");
    runBurst(1'b1, 32'h100, 4'd5, 1'b1, 1'b0, stalls);
    check("stall_cycles", 32'(stalls), 32'd6);
    tick();

    $display("[TB] unaligned start, request dropped mid-burst");
    runBurst(1'b1, 32'h07, 4'd2, 1'b0, 1'b1, stalls);
    runBurst(1'b0, 32'h04, 4'd2, 1'b0, 1'b0, stalls);

    $display("[TB] address wrap");
    runBurst(1'b1, 32'hFFFF_FFFC, 4'd1, 1'b0, 1'b0, stalls);
    tick();

    $display("[TB] reset on second beat");
    nx_dma_req = 1'b1; nx_dma_we = 1'b0; nx_dma_addr = 32'h40; nx_dma_len = 4'd3;
    tick();
    tick();
    check("beat1_before_rst", dma_beat, 1);
    nx_rst = 1'b1; nx_dma_req = 1'b0;
    tick();
    nx_rst = 1'b0;
    nx_cpu_req = 1'b1; nx_cpu_we = 1'b0; nx_cpu_addr = 32'h10;
    tick();
    check("cpu_after_reset", cpu_ready, 1);
    nx_cpu_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    $display("[TB] random traffic");
    for (int c = 0; c < 500; c++) begin
      nx_cpu_req   = ($urandom_range(0, 3) != 0);
      nx_cpu_we    = 1'($urandom_range(0, 1));
      nx_cpu_addr  = 32'($urandom_range(0, 1023));
      nx_cpu_wdata = $urandom;
      nx_dma_wdata = $urandom;
      if (!nx_dma_req && $urandom_range(0, 9) == 0) begin
        nx_dma_req  = 1'b1;
        nx_dma_we   = 1'($urandom_range(0, 1));
        nx_dma_addr = 32'($urandom_range(0, 1023));
        nx_dma_len  = 4'($urandom_range(0, 15));
      end
      nx_rst = ($urandom_range(0, 199) == 0);
      tick();
      if (model_done || nx_rst) nx_dma_req = 1'b0;
    end

    nx_rst = 1'b0; nx_cpu_req = 1'b0; nx_dma_req = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
